// File: rtl/fb_wbuf_pkg.sv
// Shared types and constants for the framebuffer DDRAM write-posting buffer.
package fb_wbuf_pkg;

  localparam int WBUF_AW = 29;

  localparam logic [7:0]  DDRAM_BURST_1 = 8'd1;
  localparam logic [15:0] DROP_CNT_MAX  = 16'hFFFF;

  typedef struct packed {
    logic [WBUF_AW-1:0] addr;
    logic [63:0]        din;
    logic [7:0]         be;
  } wbuf_entry_t;

endpackage

// File: rtl/fb_wbuf_fifo.sv
// Synchronous FIFO of write entries; only the pointers and level are reset,
// the storage array is left uninitialised.
module fb_wbuf_fifo
  import fb_wbuf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  wbuf_entry_t            din,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output wbuf_entry_t            head
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  wbuf_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(push) - LW'(pop);
    end
  end

  assign level = r_level;
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fb_ddr_wbuf.sv
// Write-posting buffer between the rotated-framebuffer writer and the DDRAM port.
// Optional same-address merge collector enabled by defining FB_WBUF_MERGE_EN.
module fb_ddr_wbuf
  import fb_wbuf_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AW           = WBUF_AW,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                   CLK_VIDEO,
  input  logic                   RESET_N,
  input  logic                   in_we,
  input  logic [AW-1:0]          in_addr,
  input  logic [63:0]            in_din,
  input  logic [7:0]             in_be,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   clr_ovf,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   DDRAM_CLK,
  input  logic                   DDRAM_BUSY,
  output logic [7:0]             DDRAM_BURSTCNT,
  output logic [AW-1:0]          DDRAM_ADDR,
  output logic [63:0]            DDRAM_DIN,
  output logic [7:0]             DDRAM_BE,
  output logic                   DDRAM_WE,
  output logic                   DDRAM_RD
);

  localparam int LW = $clog2(DEPTH) + 1;

  wbuf_entry_t   w_new;
  wbuf_entry_t   w_push_data;
  wbuf_entry_t   w_head;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic          w_ddr_we;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_nxt;

  logic          r_in_ready;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  assign w_new = '{addr: in_addr, din: in_din, be: in_be};

`ifdef FB_WBUF_MERGE_EN
  localparam int IW = $clog2(FLUSH_CYCLES) + 1;

  wbuf_entry_t   r_col;
  logic          r_col_valid;
  logic [IW-1:0] r_idle;
  wbuf_entry_t   w_merged;
  logic          w_same;
  logic          w_timeout;

  assign w_same    = r_col_valid && (r_col.addr == in_addr);
  assign w_timeout = (r_idle == IW'(FLUSH_CYCLES - 1));

  // New bytes override old ones; untouched bytes keep the collected data.
  always_comb begin
    w_merged      = r_col;
    w_merged.addr = in_addr;
    w_merged.be   = r_col.be | in_be;
    for (int b = 0; b < 8; b++) begin
      if (in_be[b]) w_merged.din[8*b +: 8] = in_din[8*b +: 8];
    end
  end

  always_comb begin
    w_push_req  = 1'b0;
    w_push_data = r_col;
    if (in_we) begin
      if (w_same) begin
        w_push_req  = flush;
        w_push_data = w_merged;
      end else if (r_col_valid) begin
        w_push_req  = 1'b1;
      end else begin
        w_push_req  = flush;
        w_push_data = w_new;
      end
    end else if (r_col_valid && (flush || w_timeout)) begin
      w_push_req = 1'b1;
    end
  end

  // A different-address write with flush can only push the old entry this
  // cycle; the new one stays collected and flushes later.
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_col       <= '0;
      r_col_valid <= 1'b0;
      r_idle      <= '0;
    end else if (in_we) begin
      r_idle <= '0;
      r_col  <= w_same ? w_merged : w_new;
      r_col_valid <= !(flush && (w_same || !r_col_valid));
    end else if (r_col_valid) begin
      if (flush || w_timeout) begin
        r_col_valid <= 1'b0;
        r_idle      <= '0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end
`else
  logic w_unused_merge;

  assign w_push_req     = in_we;
  assign w_push_data    = w_new;
  assign w_unused_merge = flush ^ (FLUSH_CYCLES != 0);
`endif

  fb_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK_VIDEO),
    .rst_n (RESET_N),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_data),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  // Handshake: the head is offered with DDRAM_WE while the FIFO is non-empty
  // and transfers on any cycle with DDRAM_WE & ~DDRAM_BUSY; it holds otherwise.
  assign w_ddr_we    = !w_empty;
  assign w_pop       = w_ddr_we && !DDRAM_BUSY;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = w_push_req && w_full && !w_pop;
  assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      r_in_ready <= 1'b1;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_in_ready <= (w_level_nxt < LW'(DEPTH));
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clr_ovf)                          r_drop_cnt <= 16'd1;
        else if (r_drop_cnt != DROP_CNT_MAX)  r_drop_cnt <= r_drop_cnt + 16'd1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign overflow       = r_overflow;
  assign drop_cnt       = r_drop_cnt;
  assign level          = w_level;
  assign DDRAM_CLK      = CLK_VIDEO;
  assign DDRAM_BURSTCNT = DDRAM_BURST_1;
  assign DDRAM_RD       = 1'b0;
  assign DDRAM_WE       = w_ddr_we;
  assign DDRAM_ADDR     = w_ddr_we ? w_head.addr : '0;
  assign DDRAM_DIN      = w_ddr_we ? w_head.din  : '0;
  assign DDRAM_BE       = w_ddr_we ? w_head.be   : '0;

endmodule
